nfc_axil_cmd_queue_regs: RTL and testbench

- AXI4-Lite register slave for the NAND flash controller. Successor to the single-command register bank.
- Adds a parametrised command FIFO so software can queue several commands. Each entry carries command, address, length, target way and both DMA addresses.
- Adds per-way ready/busy readback and sticky W1C error bits (command fail, queue overflow) with a maskable interrupt.
- Sits between the PS AXI-Lite interconnect and the NFC command sequencer; the sequencer pops entries with a valid/ready handshake.

---
 rtl/nfc_axil_cmd_queue_regs.sv | 239 +++++++++++++++++++++++
 tb/tb_nfc_axil_cmd_queue_regs.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_axil_cmd_queue_regs.sv
// AXI4-Lite register slave for the NAND flash controller with a command
// queue, per-way ready/busy readback and sticky error bits with interrupt.
module nfc_axil_cmd_queue_regs #(
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_WAYS     = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STATUS_WIDTH = 24,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    oCmdValid,
    input  logic                    iCmdReady,
    output logic [31:0]             oCommand,
    output logic [31:0]             oAddress,
    output logic [15:0]             oLength,
    output logic [WAY_W-1:0]        oWay,
    output logic [31:0]             oDMARAddress,
    output logic [31:0]             oDMAWAddress,
    output logic [5:0]              oDelayTapLoad,
    output logic                    oDelayTapValid,
    output logic                    oIrq,
    input  logic                    iCommandFail,
    input  logic [STATUS_WIDTH-1:0] iNFCStatus,
    input  logic [NUM_WAYS-1:0]     iNandRB
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 144 + WAY_W;

    logic             awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]       bresp_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      addr_q, addr_d, dmar_q, dmar_d, dmaw_q, dmaw_d;
    logic [31:0]      lastcmd_q;
    logic [15:0]      len_q, len_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic [5:0]       tap_q, tap_d;
    logic [1:0]       irq_en_q, irq_en_d;
    logic             fail_q, fail_d, ovf_q, ovf_d;
    logic             irq_q, tapv_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] head;

    logic       wr_accept, rd_accept, wr_en, rd_en;
    logic [7:0] wr_off, rd_off;
    logic       full, empty, cmd_wr, push, pop, sticky_wr;
    logic [31:0] qstat;
    logic       unused_ok;

    function automatic logic [31:0] merge32(input logic [31:0] old,
                                            input logic [31:0] d,
                                            input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign wr_off = s_axil_awaddr[9:2];
    assign rd_off = s_axil_araddr[9:2];

    assign wr_accept = s_axil_awvalid && s_axil_wvalid &&
                       (!bvalid_q || s_axil_bready) && !awready_q;
    assign rd_accept = s_axil_arvalid && (!rvalid_q || s_axil_rready) &&
                       !arready_q;
    assign wr_en = awready_q && s_axil_awvalid && s_axil_wvalid;
    assign rd_en = arready_q && s_axil_arvalid;

    // Full is judged before any same-cycle pop so a push never races a pop.
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign cmd_wr = wr_en && (wr_off == 8'd0);
    assign push   = cmd_wr && (s_axil_wstrb == 4'hF) && !full;
    assign pop    = !empty && iCmdReady;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    assign sticky_wr = wr_en && (wr_off == 8'd6);
    assign fail_d = iCommandFail |
                    (fail_q & ~(sticky_wr & s_axil_wdata[0]));
    assign ovf_d  = (cmd_wr && full) |
                    (ovf_q & ~(sticky_wr & s_axil_wdata[1]));

    assign qstat = {22'd0, full, empty, 3'd0, 5'(count_q)};

    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        dmar_d   = dmar_q;
        dmaw_d   = dmaw_q;
        way_d    = way_q;
        tap_d    = tap_q;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            case (wr_off)
                8'd1: addr_d = merge32(addr_q, s_axil_wdata, s_axil_wstrb);
                8'd2: begin
                    if (s_axil_wstrb[0]) len_d[7:0]  = s_axil_wdata[7:0];
                    if (s_axil_wstrb[1]) len_d[15:8] = s_axil_wdata[15:8];
                end
                8'd3: dmar_d = merge32(dmar_q, s_axil_wdata, s_axil_wstrb);
                8'd4: dmaw_d = merge32(dmaw_q, s_axil_wdata, s_axil_wstrb);
                8'd5: if (s_axil_wstrb[0]) way_d = s_axil_wdata[WAY_W-1:0];
                8'd9: if (s_axil_wstrb[0]) tap_d = s_axil_wdata[5:0];
                8'd11: if (s_axil_wstrb[0]) irq_en_d = s_axil_wdata[1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (rd_off)
            8'd0:  rdata_d = lastcmd_q;
            8'd1:  rdata_d = addr_q;
            8'd2:  rdata_d = {16'd0, len_q};
            8'd3:  rdata_d = dmar_q;
            8'd4:  rdata_d = dmaw_q;
            8'd5:  rdata_d = 32'(way_q);
            8'd6:  rdata_d = {30'd0, ovf_q, fail_q};
            8'd7:  rdata_d = 32'(iNFCStatus);
            8'd8:  rdata_d = 32'(iNandRB);
            8'd9:  rdata_d = {26'd0, tap_q};
            8'd10: rdata_d = qstat;
            8'd11: rdata_d = {30'd0, irq_en_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            dmar_q    <= '0;
            dmaw_q    <= '0;
            way_q     <= '0;
            tap_q     <= '0;
            irq_en_q  <= '0;
            lastcmd_q <= '0;
            fail_q    <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            tapv_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            awready_q <= wr_accept;
            arready_q <= rd_accept;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (cmd_wr && !push) ? 2'b10 : 2'b00;
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
            addr_q   <= addr_d;
            len_q    <= len_d;
            dmar_q   <= dmar_d;
            dmaw_q   <= dmaw_d;
            way_q    <= way_d;
            tap_q    <= tap_d;
            irq_en_q <= irq_en_d;
            fail_q   <= fail_d;
            ovf_q    <= ovf_d;
            irq_q    <= |({ovf_q, fail_q} & irq_en_q);
            tapv_q   <= wr_en && (wr_off == 8'd9);
            if (push) begin
                mem_q[wr_ptr_q] <= {s_axil_wdata, addr_q, len_q, way_q,
                                    dmar_q, dmaw_q};
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                lastcmd_q <= s_axil_wdata;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = awready_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;

    assign oCmdValid      = !empty;
    assign oCommand       = head[ENT_W-1 -: 32];
    assign oAddress       = head[ENT_W-33 -: 32];
    assign oLength        = head[ENT_W-65 -: 16];
    assign oWay           = head[64 +: WAY_W];
    assign oDMARAddress   = head[63:32];
    assign oDMAWAddress   = head[31:0];
    assign oDelayTapLoad  = tap_q;
    assign oDelayTapValid = tapv_q;
    assign oIrq           = irq_q;

    assign unused_ok = ^{s_axil_awaddr, s_axil_araddr,
                         s_axil_awprot, s_axil_arprot};

endmodule

// File: tb/tb_nfc_axil_cmd_queue_regs.sv
// Directed bench for nfc_axil_cmd_queue_regs: AXI-Lite register access,
// command queue ordering via a scoreboard, sticky/IRQ and backpressure.
module tb_nfc_axil_cmd_queue_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        oCmdValid, iCmdReady;
    logic [31:0] oCommand, oAddress, oDMARAddress, oDMAWAddress;
    logic [15:0] oLength;
    logic [2:0]  oWay;
    logic [5:0]  oDelayTapLoad;
    logic        oDelayTapValid, oIrq, iCommandFail;
    logic [23:0] iNFCStatus;
    logic [7:0]  iNandRB;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [15:0] len;
        logic [2:0]  way;
        logic [31:0] dmar;
        logic [31:0] dmaw;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   total = 0;
    int   bad = 0;

    logic [31:0] st_addr, st_dmar, st_dmaw;
    logic [15:0] st_len;
    logic [2:0]  st_way;

    always #5 clk = ~clk;

    nfc_axil_cmd_queue_regs dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
        .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .oCmdValid(oCmdValid), .iCmdReady(iCmdReady),
        .oCommand(oCommand), .oAddress(oAddress), .oLength(oLength),
        .oWay(oWay), .oDMARAddress(oDMARAddress),
        .oDMAWAddress(oDMAWAddress),
        .oDelayTapLoad(oDelayTapLoad), .oDelayTapValid(oDelayTapValid),
        .oIrq(oIrq), .iCommandFail(iCommandFail),
        .iNFCStatus(iNFCStatus), .iNandRB(iNandRB)
    );

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input logic [31:0] c);
        ent_t e;
        e.cmd  = c;
        e.addr = st_addr;
        e.len  = st_len;
        e.way  = st_way;
        e.dmar = st_dmar;
        e.dmaw = st_dmaw;
        return e;
    endfunction

    // Scoreboard check: every head entry taken by the sequencer.
    always @(negedge clk) begin
        if (!rst && oCmdValid && iCmdReady) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_entry", {oCommand, oAddress, oLength, oWay,
                                  oDMARAddress, oDMAWAddress}, mon_e);
            end
        end
    end

    task automatic axw(input logic [7:0] off, input logic [31:0] d,
                       input logic [3:0] s, input logic hsfail,
                       output logic [1:0] resp, output logic cv_pre);
        int n;
        tick();
        awaddr = {6'd0, off, 2'b00};
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!awready && n < 30);
        chk("awready_seen", awready, 1);
        cv_pre = oCmdValid;
        iCommandFail = hsfail;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        iCommandFail = 1'b0;
        n = 0;
        while (!bvalid && n < 30) begin
            tick();
            n++;
        end
        chk("bvalid_seen", bvalid, 1);
        resp = bresp;
    endtask

    task automatic axr(input logic [7:0] off, output logic [31:0] d);
        int n;
        tick();
        araddr = {6'd0, off, 2'b00};
        arvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!arready && n < 30);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 30) begin
            tick();
            n++;
        end
        chk("rvalid_seen", rvalid, 1);
        chk("rresp", rresp, 0);
        d = rdata;
    endtask

    initial begin
        logic [1:0]  r;
        logic        cv;
        logic [31:0] d;
        logic [31:0] exp_rd [12];
        int          n;

        rst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        iCmdReady = 0; iCommandFail = 0;
        iNFCStatus = 24'hABCDEF;
        iNandRB = 8'h5A;
        st_addr = 0; st_len = 0; st_way = 0; st_dmar = 0; st_dmaw = 0;
        repeat (3) tick();
        chk("rst_outs", {oCmdValid, oIrq, oDelayTapValid, awready,
                         bvalid, arready, rvalid}, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) exp_rd[i] = 32'h0;
        exp_rd[7]  = 32'h00ABCDEF;
        exp_rd[8]  = 32'h0000005A;
        exp_rd[10] = 32'h00000100;
        for (int i = 0; i < 12; i++) begin
            axr(8'(i), d);
            chk($sformatf("reset_rd_%0d", i), d, exp_rd[i]);
        end

        // Single queued command, sequencer stalled.
        axw(1, 32'h12345678, 4'hF, 0, r, cv); st_addr = 32'h12345678;
        axw(2, 32'h00000800, 4'hF, 0, r, cv); st_len = 16'h0800;
        axw(5, 32'h00000003, 4'hF, 0, r, cv); st_way = 3'd3;
        axw(3, 32'h10000000, 4'hF, 0, r, cv); st_dmar = 32'h10000000;
        sb.push_back(mk(32'h3000));
        axw(0, 32'h00003000, 4'hF, 0, r, cv);
        chk("cmdvalid_before", cv, 0);
        chk("cmdvalid_after", oCmdValid, 1);
        chk("cmd_bresp", r, 2'b00);
        chk("head", {oCommand, oAddress, oLength, oWay, oDMARAddress,
                     oDMAWAddress},
            {32'h3000, 32'h12345678, 16'h0800, 3'd3, 32'h10000000, 32'h0});
        axr(10, d); chk("qstat_1", d, 32'h001);
        axr(0, d);  chk("lastcmd", d, 32'h3000);

        // Fill then overflow.
        for (int i = 1; i < 4; i++) begin
            sb.push_back(mk(32'h3000 + i));
            axw(0, 32'h3000 + i, 4'hF, 0, r, cv);
            chk($sformatf("fill_bresp_%0d", i), r, 2'b00);
        end
        axw(0, 32'h3004, 4'hF, 0, r, cv);
        chk("ovf_bresp", r, 2'b10);
        axr(6, d);  chk("sticky_ovf", d, 32'h2);
        axr(10, d); chk("qstat_full", d, 32'h204);
        axr(0, d);  chk("lastcmd_ovf", d, 32'h3003);
        axw(6, 32'h2, 4'hF, 0, r, cv);
        axr(6, d);  chk("sticky_w1c", d, 32'h0);

        // Drain in order.
        tick();
        iCmdReady = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (oCmdValid && n < 40);
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", oCmdValid, 0);

        // Back-to-back pushes while the sequencer keeps up.
        axw(4, 32'hDEAD0000, 4'hF, 0, r, cv); st_dmaw = 32'hDEAD0000;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(32'h5000 + i));
            axw(0, 32'h5000 + i, 4'hF, 0, r, cv);
            chk($sformatf("conc_pre_%0d", i), cv, 0);
        end
        n = 0;
        while (oCmdValid && n < 20) begin
            tick();
            n++;
        end
        chk("conc_sb", sb.size(), 0);
        axr(10, d); chk("qstat_conc", d, 32'h100);
        iCmdReady = 1'b0;

        // Sticky fail and interrupt.
        axw(11, 32'h1, 4'hF, 0, r, cv);
        tick();
        iCommandFail = 1'b1;
        tick();
        iCommandFail = 1'b0;
        chk("irq_lat0", oIrq, 0);
        tick();
        chk("irq_lat1", oIrq, 1);
        axw(6, 32'h1, 4'hF, 1, r, cv);
        axr(6, d); chk("fail_set_wins", d, 32'h1);
        axw(6, 32'h1, 4'hF, 0, r, cv);
        axr(6, d); chk("fail_cleared", d, 32'h0);
        chk("irq_cleared", oIrq, 0);

        // Delay tap pulse.
        axw(9, 32'hFFFFFFEA, 4'hF, 0, r, cv);
        chk("tap_pulse", {oDelayTapValid, oDelayTapLoad}, {1'b1, 6'h2A});
        tick();
        chk("tap_pulse_end", oDelayTapValid, 0);

        // Byte strobes.
        axw(1, 32'h0, 4'hF, 0, r, cv);
        axw(1, 32'hAABBCCDD, 4'h3, 0, r, cv);
        axr(1, d); chk("strb_lo", d, 32'h0000CCDD);
        axw(1, 32'h11223344, 4'h8, 0, r, cv);
        axr(1, d); chk("strb_hi", d, 32'h1100CCDD);
        axw(0, 32'h7777, 4'h7, 0, r, cv);
        chk("partial_cmd_bresp", r, 2'b10);
        axr(10, d); chk("partial_cmd_qstat", d, 32'h100);
        axr(6, d);  chk("partial_cmd_sticky", d, 32'h0);

        // Read backpressure with a second read pending.
        tick();
        rready = 1'b0;
        araddr = 16'h0004;
        arvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!arready && n < 30);
        tick();
        araddr = 16'h0028;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_%0d", i), {rvalid, rdata, arready},
                {1'b1, 32'h1100CCDD, 1'b0});
        end
        rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_second_rd", {rvalid, rdata}, {1'b1, 32'h100});

        // Reset with entries queued discards them.
        axw(0, 32'h9000, 4'hF, 0, r, cv);
        axw(0, 32'h9001, 4'hF, 0, r, cv);
        chk("pre_rst_valid", oCmdValid, 1);
        tick();
        rst = 1'b1;
        #2;
        chk("rst_async", {oCmdValid, bvalid, oIrq}, 0);
        tick();
        rst = 1'b0;
        sb.delete();
        axr(10, d); chk("rst_qstat", d, 32'h100);
        axr(1, d);  chk("rst_addr", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
